game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the World / mp3 / Display datapath.
- Runs on the game clock, 40 Hz in the top level.
- Decides when World is held in reset or allowed to run, and which mp3 track plays.
- Owns the lives counter and the level countdown timer, and drives the time-bonus tally at level clear.

Parameters:
- LIVES_INIT, 3: lives loaded on game start (1..15).
- TIME_INIT, 400: level time in game-seconds loaded on each LOAD.
- TICKS_PER_SEC, 40: clk cycles per game-second.
- LOAD_TICKS, 40: cycles World is held in reset in LOAD.
- DEATH_TICKS, 120: cycles spent in DYING.
- END_TICKS, 160: cycles held in GAMEOVER, and in CLEAR after the tally.
- HURRY_TIME, 100: time_left threshold for hurry.

Ports:
- clk  in  1  game clock (clk_40 domain)
- rst  in  1  reset, synchronous, active-high
- start  in  1  start key level (jump key); rising edge used
- mario_dead  in  1  level from World: Mario killed (enemy or fall)
- goal_reached  in  1  level from World: flagpole reached
- pause  in  1  pause key level; used only with PAUSE_EN
- world_rst  out  1  active-high reset to World
- world_run  out  1  World physics enable
- track_sel  out  2  0 silence/title, 1 overworld, 2 death, 3 fanfare
- hurry  out  1  time_left < HURRY_TIME while in PLAY
- lives  out  4  remaining lives
- time_left  out  10  level seconds remaining
- bonus_pulse  out  1  one-cycle strobe: add 50 points
- state  out  3  0 TITLE, 1 LOAD, 2 PLAY, 3 DYING, 4 GAMEOVER, 5 CLEAR, 6 PAUSED

Behaviour:
- Reset (rst=1 at a clk edge). All of the following hold from the next cycle:
  - state = TITLE, world_rst = 1, world_run = 0, track_sel = 0.
  - lives = LIVES_INIT, time_left = TIME_INIT.
  - bonus_pulse = 0, hurry = 0, all counters = 0.
  - start_prev = 1, so a key held through reset does not register as an edge.
- Reset mid-operation aborts any state immediately.
- Start edge: start_edge = start & ~start_prev, with start_prev registered every cycle.
- All outputs are registered and change on the cycle the state is entered.
- TITLE:
  - Outputs: world_rst = 1, run = 0, track = 0.
  - On start_edge: lives <= LIVES_INIT, go to LOAD.
- LOAD:
  - Outputs: world_rst = 1, run = 0, track = 0.
  - time_left <= TIME_INIT and sec_cnt <= 0 on entry.
  - After LOAD_TICKS cycles, go to PLAY.
- PLAY:
  - Outputs: world_rst = 0, run = 1, track = 1.
  - sec_cnt counts 0..TICKS_PER_SEC-1. On wrap, time_left decrements, saturating at 0.
  - Priority when events coincide in the same cycle: goal_reached > mario_dead > (time_left == 0).
    - goal_reached: go to CLEAR.
    - mario_dead, or time_left == 0: go to DYING.
  - A goal and a timeout in the same cycle therefore gives CLEAR.
- DYING:
  - Outputs: run = 0, world_rst = 0 (World frame frozen), track = 2.
  - After DEATH_TICKS: if lives == 1, set lives <= 0 and go to GAMEOVER; otherwise lives <= lives-1 and go to LOAD.
  - lives never underflows.
- GAMEOVER:
  - Outputs: run = 0, track = 0.
  - After END_TICKS, go to TITLE. start_edge is ignored here.
- CLEAR:
  - Outputs: run = 0, track = 3.
  - Tally: while time_left > 0, each cycle decrements time_left by 1 and asserts bonus_pulse for that cycle. Exactly TIME_INIT-style count: N pulses for N remaining seconds.
  - When time_left == 0, bonus_pulse = 0. After END_TICKS further cycles, go to TITLE.
- Timer: one shared phase counter, 8 bits, cleared on every state entry.
- Inputs are already synchronous to clk; no synchronisers inside the block.

Optional Feature:
- Macro: GAME_FLOW_PAUSE_EN.
- Defined:
  - pause rising edge (edge-detected like start, prev reset to 1) in PLAY goes to PAUSED.
  - PAUSED outputs: run = 0, world_rst = 0, track = 0. sec_cnt and time_left are frozen.
  - A pause edge in PAUSED returns to PLAY with sec_cnt preserved.
  - mario_dead and goal_reached are ignored in PAUSED.
- Not defined: pause is unused, and state value 6 is never produced.

Test Plan:
1. Reset, then start held high. No transition while start stays high. Release, then re-press: TITLE -> LOAD. world_rst = 1 for exactly 40 cycles, then PLAY with run = 1, track = 1, time_left = 400.
2. PLAY for 40 cycles -> time_left = 399. Force time_left to 100 then 99: hurry goes 0 then 1.
3. mario_dead pulse with lives = 3 -> DYING, track = 2, 120 cycles. Then lives = 2 and LOAD, time_left reloaded to 400.
4. Three deaths from game start -> lives = 0, GAMEOVER. After 160 cycles -> TITLE, track = 0.
5. goal_reached and mario_dead in the same cycle with time_left = 5 -> CLEAR. Exactly 5 bonus_pulse strobes on consecutive cycles, time_left ends at 0, TITLE after 160 more cycles.
6. rst asserted mid-DYING -> next cycle state = TITLE, lives = 3, world_rst = 1. With GAME_FLOW_PAUSE_EN: a pause edge in PLAY freezes time_left for 200 cycles, and a second edge resumes.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game sequencer with lives, level timer and clear tally; define GAME_FLOW_PAUSE_EN to add the PAUSED state
module game_flow_ctrl #(
    parameter int LIVES_INIT    = 3,
    parameter int TIME_INIT     = 400,
    parameter int TICKS_PER_SEC = 40,
    parameter int LOAD_TICKS    = 40,
    parameter int DEATH_TICKS   = 120,
    parameter int END_TICKS     = 160,
    parameter int HURRY_TIME    = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mario_dead,
    input  logic       goal_reached,
    input  logic       pause,
    output logic       world_rst,
    output logic       world_run,
    output logic [1:0] track_sel,
    output logic       hurry,
    output logic [3:0] lives,
    output logic [9:0] time_left,
    output logic       bonus_pulse,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        TITLE    = 3'd0,
        LOAD     = 3'd1,
        PLAY     = 3'd2,
        DYING    = 3'd3,
        GAMEOVER = 3'd4,
        CLEAR    = 3'd5,
        PAUSED   = 3'd6
    } state_t;
    state_t     cur, nxt;
    logic [7:0] phase, nxt_phase, sec_cnt, nxt_sec;
    logic [9:0] nxt_time;
    logic [3:0] nxt_lives;
    logic       nxt_bonus, start_prev, start_edge, pause_edge, tick;
    assign start_edge = start & ~start_prev;
    assign state      = cur;
    assign tick       = sec_cnt == 8'(TICKS_PER_SEC - 1);
`ifdef GAME_FLOW_PAUSE_EN
    logic pause_prev;
    assign pause_edge = pause & ~pause_prev;
    always_ff @(posedge clk) pause_prev <= rst ? 1'b1 : pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_edge   = 1'b0;
`endif
    always_comb begin
        nxt       = cur;
        nxt_phase = phase + 8'd1;
        nxt_sec   = sec_cnt;
        nxt_time  = time_left;
        nxt_lives = lives;
        nxt_bonus = 1'b0;
        case (cur)
            TITLE: if (start_edge) begin
                nxt       = LOAD;
                nxt_lives = 4'(LIVES_INIT);
            end
            LOAD: if (phase == 8'(LOAD_TICKS - 1)) nxt = PLAY;
            PLAY: begin
                if (goal_reached) nxt = CLEAR;
                else if (mario_dead || time_left == 10'd0) nxt = DYING;
                else if (pause_edge) nxt = PAUSED;
                else begin
                    nxt_sec  = tick ? 8'd0 : sec_cnt + 8'd1;
                    nxt_time = (tick && time_left != 10'd0) ? time_left - 10'd1 : time_left;
                end
            end
            DYING: if (phase == 8'(DEATH_TICKS - 1)) begin
                nxt       = lives > 4'd1 ? LOAD : GAMEOVER;
                nxt_lives = lives > 4'd1 ? lives - 4'd1 : 4'd0;
            end
            GAMEOVER: if (phase == 8'(END_TICKS - 1)) nxt = TITLE;
            // the hold period only starts counting once the tally has drained
            CLEAR: if (time_left != 10'd0) begin
                nxt_time  = time_left - 10'd1;
                nxt_bonus = 1'b1;
                nxt_phase = 8'd0;
            end else if (phase == 8'(END_TICKS - 1)) nxt = TITLE;
            PAUSED: if (pause_edge) nxt = PLAY;
            default: nxt = TITLE;
        endcase
        if (nxt != cur) nxt_phase = 8'd0;
        if (nxt == LOAD && cur != LOAD) begin
            nxt_time = 10'(TIME_INIT);
            nxt_sec  = 8'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= TITLE;
            phase       <= 8'd0;
            sec_cnt     <= 8'd0;
            time_left   <= 10'(TIME_INIT);
            lives       <= 4'(LIVES_INIT);
            start_prev  <= 1'b1;
            bonus_pulse <= 1'b0;
            hurry       <= 1'b0;
            world_rst   <= 1'b1;
            world_run   <= 1'b0;
            track_sel   <= 2'd0;
        end else begin
            cur         <= nxt;
            phase       <= nxt_phase;
            sec_cnt     <= nxt_sec;
            time_left   <= nxt_time;
            lives       <= nxt_lives;
            start_prev  <= start;
            bonus_pulse <= nxt_bonus;
            hurry       <= nxt == PLAY && nxt_time < 10'(HURRY_TIME);
            world_rst   <= nxt == TITLE || nxt == LOAD;
            world_run   <= nxt == PLAY;
            track_sel   <= nxt == PLAY ? 2'd1 : nxt == DYING ? 2'd2 : nxt == CLEAR ? 2'd3 : 2'd0;
        end
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: vector table, corner sequences and randomized run against a remaining-cycles model
module tb_game_flow_ctrl;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, mario_dead = 1'b0, goal_reached = 1'b0, pause = 1'b0;
    logic       world_rst, world_run, hurry, bonus_pulse;
    logic [1:0] track_sel;
    logic [3:0] lives;
    logic [9:0] time_left;
    logic [2:0] state;
    logic [21:0] dut_v;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    game_flow_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mario_dead(mario_dead), .goal_reached(goal_reached),
        .pause(pause), .world_rst(world_rst), .world_run(world_run), .track_sel(track_sel),
        .hurry(hurry), .lives(lives), .time_left(time_left), .bonus_pulse(bonus_pulse), .state(state)
    );
    assign dut_v = {state, lives, time_left, world_rst, world_run, track_sel, hurry, bonus_pulse};
    typedef struct {
        bit s, d, g;
        int n, st, lv, tl;
        bit bp;
    } vec_t;
    vec_t tbl[$];
    function automatic void add(bit s, bit d, bit g, int n, int st, int lv, int tl);
        vec_t v;
        v.s = s; v.d = d; v.g = g; v.n = n; v.st = st; v.lv = lv; v.tl = tl; v.bp = 1'b0;
        tbl.push_back(v);
    endfunction
    function automatic logic [21:0] exp_v(int st, int lv, int tl, bit bp);
        logic [1:0] trk;
        trk = st == 2 ? 2'd1 : st == 3 ? 2'd2 : st == 5 ? 2'd3 : 2'd0;
        return {3'(st), 4'(lv), 10'(tl), st <= 1, st == 2, trk, st == 2 && tl < 100, bp};
    endfunction
    task automatic chk(string nm, logic [21:0] act, logic [21:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d lv=%0d tl=%0d flags=%b, expected st=%0d lv=%0d tl=%0d flags=%b",
                     nm, act[21:19], act[18:15], act[14:5], act[4:0], exp[21:19], exp[18:15], exp[14:5], exp[4:0]);
        end
    endtask
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // model: each timed state carries the cycles it still has to run
    int m_st, m_lv, m_tl, m_left, m_sub;
    bit m_bp, m_sp, m_pp;
    function automatic void m_reset();
        m_st = 0; m_lv = 3; m_tl = 400; m_left = 0; m_sub = 0; m_bp = 0; m_sp = 1; m_pp = 1;
    endfunction
    function automatic void m_load();
        m_st = 1; m_left = 40; m_tl = 400; m_sub = 0;
    endfunction
    function automatic void m_step(bit s, bit d, bit g, bit p);
        bit se, pe;
        se = s && !m_sp;
`ifdef GAME_FLOW_PAUSE_EN
        pe = p && !m_pp;
`else
        pe = 0;
`endif
        m_sp = s; m_pp = p; m_bp = 0;
        case (m_st)
            0: if (se) begin m_lv = 3; m_load(); end
            1: begin m_left--; if (m_left == 0) m_st = 2; end
            2: if (g) begin m_st = 5; m_left = 160; end
               else if (d || m_tl == 0) begin m_st = 3; m_left = 120; end
               else if (pe) m_st = 6;
               else begin
                   m_sub++;
                   if (m_sub == 40) begin m_sub = 0; if (m_tl > 0) m_tl--; end
               end
            3: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lv <= 1) begin m_lv = 0; m_st = 4; m_left = 160; end
                    else begin m_lv--; m_load(); end
                end
            end
            4: begin m_left--; if (m_left == 0) m_st = 0; end
            5: if (m_tl > 0) begin m_tl--; m_bp = 1; end
               else begin m_left--; if (m_left == 0) m_st = 0; end
            6: if (pe) m_st = 2;
            default: m_st = 0;
        endcase
    endfunction
    initial begin
        start = 1; rst = 1;
        cyc(2);
        chk("reset", dut_v, exp_v(0, 3, 400, 0));
        rst = 0;
        add(1,0,0,1,0,3,400);     add(1,0,0,5,0,3,400);     add(0,0,0,1,0,3,400);
        add(1,0,0,1,1,3,400);     add(0,0,0,38,1,3,400);    add(0,0,0,1,1,3,400);
        add(0,0,0,1,2,3,400);     add(0,0,0,39,2,3,400);    add(0,0,0,1,2,3,399);
        add(0,0,0,11960,2,3,100); add(0,0,0,40,2,3,99);
        add(0,1,0,1,3,3,99);      add(0,0,0,118,3,3,99);    add(0,0,0,1,3,3,99);
        add(0,0,0,1,1,2,400);     add(0,0,0,39,1,2,400);    add(0,0,0,1,2,2,400);
        add(0,1,0,1,3,2,400);     add(0,0,0,119,3,2,400);   add(0,0,0,1,1,1,400);
        add(0,0,0,40,2,1,400);    add(0,1,0,1,3,1,400);     add(0,0,0,119,3,1,400);
        add(0,0,0,1,4,0,400);     add(1,0,0,1,4,0,400);     add(0,0,0,1,4,0,400);
        add(1,0,0,157,4,0,400);   add(0,0,0,1,0,0,400);     add(1,0,0,1,1,3,400);
        add(0,0,0,40,2,3,400);    add(0,0,0,15800,2,3,5);   add(0,1,1,1,5,3,5);
        foreach (tbl[i]) begin
            start = tbl[i].s; mario_dead = tbl[i].d; goal_reached = tbl[i].g;
            cyc(tbl[i].n);
            chk($sformatf("vec%0d", i), dut_v, exp_v(tbl[i].st, tbl[i].lv, tbl[i].tl, tbl[i].bp));
        end
        start = 0; mario_dead = 0; goal_reached = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk($sformatf("tally%0d", i), dut_v, exp_v(5, 3, 4 - i, 1));
        end
        cyc(1);   chk("tally_done", dut_v, exp_v(5, 3, 0, 0));
        cyc(158); chk("clear_hold", dut_v, exp_v(5, 3, 0, 0));
        cyc(1);   chk("clear_exit", dut_v, exp_v(0, 3, 0, 0));
        start = 1; cyc(1); start = 0; cyc(40);
        mario_dead = 1; cyc(1); mario_dead = 0; cyc(120);
        chk("relive", dut_v, exp_v(1, 2, 400, 0));
        cyc(40); mario_dead = 1; cyc(1); mario_dead = 0; cyc(50);
        chk("mid_dying", dut_v, exp_v(3, 2, 400, 0));
        rst = 1; cyc(1);
        chk("rst_dying", dut_v, exp_v(0, 3, 400, 0));
        rst = 0;
`ifdef GAME_FLOW_PAUSE_EN
        start = 1; cyc(1); start = 0; cyc(40); cyc(20);
        pause = 1; cyc(1);
        chk("pause_in", dut_v, exp_v(6, 3, 400, 0));
        pause = 0; mario_dead = 1; goal_reached = 1; cyc(200);
        chk("pause_hold", dut_v, exp_v(6, 3, 400, 0));
        mario_dead = 0; goal_reached = 0; pause = 1; cyc(1);
        chk("pause_out", dut_v, exp_v(2, 3, 400, 0));
        cyc(19); chk("sec_kept", dut_v, exp_v(2, 3, 400, 0));
        cyc(1);  chk("sec_wrap", dut_v, exp_v(2, 3, 399, 0));
        pause = 0;
`endif
        rst = 1; cyc(1); m_reset();
        chk("rand_reset", dut_v, exp_v(m_st, m_lv, m_tl, m_bp));
        for (int i = 0; i < 8000; i++) begin
            rst          = $urandom_range(0, 2999) == 0;
            start        = $urandom_range(0, 3) == 0;
            mario_dead   = $urandom_range(0, 299) == 0;
            goal_reached = $urandom_range(0, 499) == 0;
            pause        = $urandom_range(0, 149) == 0;
            @(posedge clk);
            if (rst) m_reset();
            else m_step(start, mario_dead, goal_reached, pause);
            #1;
            chk($sformatf("rand%0d", i), dut_v, exp_v(m_st, m_lv, m_tl, m_bp));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
